simplez_core: RTL and testbench

Parametrised Simplez CPU core: the complete fetch/decode/execute sequencer and datapath (CP, RI, AC) for the eight-instruction Simplez ISA. It is generalised in address width and adds single-step control plus a memory-mapped LED output port. It sits between an external synchronous RAM (one-cycle read latency) and the board top level, which instantiates the core, the memory and the pin wiring.

---
 rtl/simplez_core_pkg.sv | 28 ++
 rtl/simplez_seq.sv | 101 ++++++++++
 rtl/simplez_core.sv | 80 ++++++++
 tb/tb_simplez_core.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplez_core_pkg.sv
// Shared Simplez definitions: opcodes, sequencer states and decode helpers.
package simplez_core_pkg;

  typedef enum logic [2:0] {
    OP_ST   = 3'd0,
    OP_LD   = 3'd1,
    OP_ADD  = 3'd2,
    OP_BR   = 3'd3,
    OP_BZ   = 3'd4,
    OP_CLR  = 3'd5,
    OP_DEC  = 3'd6,
    OP_HALT = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_I0,
    S_I1,
    S_O0,
    S_O1,
    S_HLT
  } state_e;

  // ST, LD and ADD need a memory operand cycle (O0); the rest skip to O1.
  function automatic logic has_operand(opcode_e op);
    return (op == OP_ST) || (op == OP_LD) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/simplez_seq.sv
// Simplez sequencer: state register, next-state logic and micro-order decode.
module simplez_seq
  import simplez_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  input  logic       step,
  input  logic [2:0] fetch_op,
  input  logic [2:0] ri_op,
  input  logic       ac_zero,
  input  logic       cd_is_io,
  output logic       ld_ri,
  output logic       inc_cp,
  output logic       sel_cd,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       led_wr,
  output logic       ac_ld,
  output logic       ac_add,
  output logic       ac_clr,
  output logic       ac_dec,
  output logic       cp_ld,
  output logic       stop
);

  state_e  state;
  opcode_e op;
  logic    hold;

  assign op   = opcode_e'(ri_op);
  assign hold = step_en & ~step;
  assign stop = (state == S_HLT);

  // In I1 RI is still loading, so the branch to O0/O1 decodes the bus word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_I0;
    end else begin
      case (state)
        S_I0:    if (!hold) state <= S_I1;
        S_I1:    state <= has_operand(opcode_e'(fetch_op)) ? S_O0 : S_O1;
        S_O0:    state <= S_O1;
        S_O1:    state <= (op == OP_HALT) ? S_HLT : S_I0;
        S_HLT:   state <= S_HLT;
        default: state <= S_I0;
      endcase
    end
  end

  always_comb begin
    ld_ri  = 1'b0;
    inc_cp = 1'b0;
    sel_cd = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    led_wr = 1'b0;
    ac_ld  = 1'b0;
    ac_add = 1'b0;
    ac_clr = 1'b0;
    ac_dec = 1'b0;
    cp_ld  = 1'b0;
    case (state)
      S_I0: mem_rd = ~hold;
      S_I1: begin
        ld_ri  = 1'b1;
        inc_cp = 1'b1;
      end
      S_O0: begin
        sel_cd = 1'b1;
        case (op)
          OP_LD, OP_ADD: mem_rd = 1'b1;
          OP_ST: begin
            led_wr = cd_is_io;
            mem_wr = ~cd_is_io;
          end
          default: ;
        endcase
      end
      S_O1: begin
        case (op)
          OP_LD:   ac_ld  = 1'b1;
          OP_ADD:  ac_add = 1'b1;
          OP_BR:   cp_ld  = 1'b1;
          OP_BZ:   cp_ld  = ac_zero;
          OP_CLR:  ac_clr = 1'b1;
          OP_DEC:  ac_dec = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    // Abort any in-flight access: no memory or LED side effect under reset.
    if (rst) begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      led_wr = 1'b0;
    end
  end

endmodule

// File: rtl/simplez_core.sv
// Simplez CPU core: CP/RI/AC registers, LED port and datapath around simplez_seq.
module simplez_core
  import simplez_core_pkg::*;
#(
  parameter int unsigned ADDRW    = 9,
  parameter int unsigned LEDW     = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned IO_ADDR  = (1 << ADDRW) - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_en,
  input  logic               step,
  output logic [ADDRW-1:0]   mem_addr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [ADDRW+2:0]   mem_wdata,
  input  logic [ADDRW+2:0]   mem_rdata,
  output logic [LEDW-1:0]    leds,
  output logic               stop
);

  localparam int unsigned DATAW = ADDRW + 3;

  logic [ADDRW-1:0] cp;
  logic [DATAW-1:0] ri;
  logic [DATAW-1:0] ac;
  logic [ADDRW-1:0] cd;
  logic             ld_ri, inc_cp, sel_cd, led_wr;
  logic             ac_ld, ac_add, ac_clr, ac_dec, cp_ld;

  assign cd        = ri[ADDRW-1:0];
  assign mem_addr  = sel_cd ? cd : cp;
  assign mem_wdata = ac;

  simplez_seq u_seq (
    .clk      (clk),
    .rst      (rst),
    .step_en  (step_en),
    .step     (step),
    .fetch_op (mem_rdata[DATAW-1:ADDRW]),
    .ri_op    (ri[DATAW-1:ADDRW]),
    .ac_zero  (ac == '0),
    .cd_is_io (cd == ADDRW'(IO_ADDR)),
    .ld_ri    (ld_ri),
    .inc_cp   (inc_cp),
    .sel_cd   (sel_cd),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .led_wr   (led_wr),
    .ac_ld    (ac_ld),
    .ac_add   (ac_add),
    .ac_clr   (ac_clr),
    .ac_dec   (ac_dec),
    .cp_ld    (cp_ld),
    .stop     (stop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cp   <= ADDRW'(RESET_PC);
      ri   <= '0;
      ac   <= '0;
      leds <= '0;
    end else begin
      if (ld_ri) ri <= mem_rdata;

      if (inc_cp)     cp <= cp + 1'b1;
      else if (cp_ld) cp <= cd;

      if (ac_ld)       ac <= mem_rdata;
      else if (ac_add) ac <= ac + mem_rdata;
      else if (ac_clr) ac <= '0;
      else if (ac_dec) ac <= ac - 1'b1;

      if (led_wr) leds <= ac[LEDW-1:0];
    end
  end

endmodule

// File: tb/tb_simplez_core.sv
// Self-checking bench for simplez_core with a behavioural one-cycle-latency RAM.
module tb_simplez_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_en = 1'b0;
  logic        step = 1'b0;
  logic [8:0]  mem_addr;
  logic        mem_rd, mem_wr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [3:0]  leds;
  logic        stop;

  logic        tb_we = 1'b0;
  logic [8:0]  tb_addr = '0;
  logic [11:0] tb_data = '0;
  logic [11:0] mem [512];
  int unsigned rd_count = 0;
  int unsigned wr_count = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_item_t;
  sb_item_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  simplez_core #(
    .ADDRW    (9),
    .LEDW     (4),
    .RESET_PC (0),
    .IO_ADDR  (511)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .step_en   (step_en),
    .step      (step),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .leds      (leds),
    .stop      (stop)
  );

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_rd) rd_count <= rd_count + 1;
    if (mem_wr) wr_count <= wr_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_item_t it;
    it.tag = tag;
    it.val = val;
    exp_q.push_back(it);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    sb_item_t it;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      it = exp_q.pop_front();
      check(it.tag, obs, it.val);
    end
  endtask

  task automatic poke(input int unsigned a, input logic [11:0] d);
    tb_addr = a[8:0];
    tb_data = d;
    tb_we   = 1'b1;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic start_test(input logic se);
    @(negedge clk);
    rst     = 1'b1;
    step    = 1'b0;
    step_en = se;
    for (int unsigned i = 0; i < 512; i++) poke(i, 12'o0000);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_stop(input int budget, output int n);
    n = 0;
    while (!stop && n < budget) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, n2;
    int unsigned r0, w0;

    // Basic program: LD, ADD, ST, HALT
    start_test(1'b0);
    poke(0, 12'o1010); poke(1, 12'o2011); poke(2, 12'o0012); poke(3, 12'o7000);
    poke(8, 12'o0005); poke(9, 12'o0007);
    sb_push("prog_cycles", 15);
    sb_push("prog_m12", 12'o0014);
    sb_push("prog_cp", 4);
    sb_push("prog_ac", 12'o0014);
    release_rst();
    run_until_stop(100, n);
    sb_pop(n);
    sb_pop(mem[8'o12]);
    sb_pop(dut.cp);
    sb_pop(mem_wdata);
    sb_push("hlt_hold_rd", 0);
    r0 = rd_count;
    edges(5);
    sb_pop(rd_count - r0);

    // LED port: AC=0o12 then ST /777
    start_test(1'b0);
    poke(0, 12'o1010); poke(1, 12'o0777); poke(2, 12'o7000);
    poke(8, 12'o0012); poke(9'o777, 12'o1234);
    sb_push("led_cycles", 11);
    sb_push("led_value", 4'hA);
    sb_push("led_no_wr", 0);
    sb_push("led_m777", 12'o1234);
    release_rst();
    w0 = wr_count;
    run_until_stop(100, n);
    sb_pop(n);
    sb_pop(leds);
    sb_pop(wr_count - w0);
    sb_pop(mem[9'o777]);

    // Reset state, sampled while rst is still held after the LED test
    start_test(1'b0);
    sb_push("rst_mem_rd", 0);
    sb_push("rst_mem_wr", 0);
    sb_push("rst_stop", 0);
    sb_push("rst_leds", 0);
    sb_push("rst_ac", 0);
    sb_push("rst_cp", 0);
    sb_pop(mem_rd);
    sb_pop(mem_wr);
    sb_pop(stop);
    sb_pop(leds);
    sb_pop(mem_wdata);
    sb_pop(dut.cp);

    // Branches: CLR; BZ /5 taken, DEC; BZ /0 not taken
    poke(0, 12'o5000); poke(1, 12'o4005);
    poke(2, 12'o7000); poke(3, 12'o7000); poke(4, 12'o7000);
    poke(5, 12'o6000); poke(6, 12'o4000); poke(7, 12'o7000);
    sb_push("bz_taken_cp", 5);
    sb_push("br_cycles", 15);
    sb_push("bz_not_taken_cp", 8);
    sb_push("dec_ac", 12'o7777);
    release_rst();
    edges(6);
    sb_pop(dut.cp);
    run_until_stop(100, n2);
    sb_pop(6 + n2);
    sb_pop(dut.cp);
    sb_pop(mem_wdata);

    // Wrap: AC overflow to 0, CP wrap from 0o777 to 0
    start_test(1'b0);
    poke(0, 12'o4003); poke(1, 12'o7000); poke(2, 12'o7000);
    poke(3, 12'o1020); poke(4, 12'o2021); poke(5, 12'o0023);
    poke(6, 12'o6000); poke(7, 12'o3777);
    poke(8'o20, 12'o7777); poke(8'o21, 12'o0001); poke(8'o23, 12'o5555);
    poke(9'o777, 12'o0022);
    sb_push("wrap_cycles", 31);
    sb_push("wrap_add_zero", 0);
    sb_push("wrap_m22", 12'o7777);
    sb_push("wrap_cp", 2);
    release_rst();
    run_until_stop(200, n);
    sb_pop(n);
    sb_pop(mem[8'o23]);
    sb_pop(mem[8'o22]);
    sb_pop(dut.cp);

    // Single-step mode
    start_test(1'b1);
    poke(0, 12'o1010); poke(1, 12'o7000); poke(8, 12'o0033);
    sb_push("step_idle_rd", 0);
    sb_push("step_idle_cp", 0);
    sb_push("step_ld_rd", 2);
    sb_push("step_ld_ac", 12'o0033);
    sb_push("step_ld_cp", 1);
    sb_push("step_hold_rd", 0);
    sb_push("step_hold_stop", 0);
    release_rst();
    r0 = rd_count;
    edges(20);
    sb_pop(rd_count - r0);
    sb_pop(dut.cp);
    r0 = rd_count;
    step = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step = 1'b0;
    edges(3);
    sb_pop(rd_count - r0);
    sb_pop(mem_wdata);
    sb_pop(dut.cp);
    r0 = rd_count;
    edges(10);
    sb_pop(rd_count - r0);
    sb_pop(stop);

    // Reset during the O0 cycle of ST /12
    start_test(1'b0);
    poke(0, 12'o1010); poke(1, 12'o0012); poke(2, 12'o7000);
    poke(8, 12'o0077); poke(8'o12, 12'o4321);
    sb_push("abort_o0_wr_before", 1);
    sb_push("abort_o0_wr", 0);
    sb_push("abort_cp", 0);
    sb_push("abort_ac", 0);
    sb_push("abort_m12", 12'o4321);
    sb_push("abort_wr_count", 0);
    release_rst();
    w0 = wr_count;
    edges(6);
    sb_pop(mem_wr);
    rst = 1'b1;
    #1;
    sb_pop(mem_wr);
    edges(1);
    sb_pop(dut.cp);
    sb_pop(mem_wdata);
    sb_pop(mem[8'o12]);
    sb_pop(wr_count - w0);

    if (exp_q.size() != 0) check("sb_leftover", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
